reverb_delay_ctrl: RTL and testbench
====================================

# reverb_delay_ctrl

Sequencer for the FIFO-based reverb delay line. It generates the FIFO write/read enables at the audio sample rate and keeps the FIFO occupancy equal to the programmed delay in samples. It accepts delay-change requests through a valid/ready handshake. Each change is glitch-free: fade wet gain to 0, grow or shrink occupancy to the new delay, then fade back in. It sits between the audio front end (sample strobe, delay setting) and the delay FIFO and wet/dry mixer.

## Interface
- DLY_W, 13, width of delay and occupancy counters
- MAX_DELAY, 8191, largest legal delay (FIFO depth − 1)
- DEFAULT_DELAY, 1000, delay used after reset
- GAIN_STEP, 8, wet-gain increment/decrement per sample during fades
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- sample_en  in  1  one-cycle strobe per audio sample
- delay_req  in  DLY_W  requested delay in samples
- delay_req_valid  in  1  request valid
- delay_req_ready  out  1  request accepted when valid&&ready at a clk edge
- fifo_empty  in  1  delay FIFO empty flag
- fifo_full  in  1  delay FIFO full flag
- fifo_wr_en  out  1  FIFO write enable, one-cycle pulse
- fifo_rd_en  out  1  FIFO read enable, one-cycle pulse
- wet_gain  out  8  wet-path gain to mixer, 0..255
- delay_cur  out  DLY_W  delay currently in effect
- busy  out  1  high in every state except RUN
- err_xrun  out  1  sticky: a read was suppressed on empty, or a write on full

## Operation
- States: FILL, DRAIN, FADE_IN, RUN, FADE_OUT. State register reset value: FILL.
- The register `fill_cnt` (DLY_W bits) tracks FIFO occupancy. It is incremented on each issued write without a read, and decremented on each issued read without a write.
- Target clamp for an accepted request: 0 → 1, and any value above MAX_DELAY → MAX_DELAY. The clamped value is latched into `delay_nxt`.
- **FILL:** on each sample_en, write only, and fill_cnt += 1. If the new fill_cnt equals delay_cur, go to FADE_IN.
- **DRAIN:** on each sample_en, read only, and fill_cnt −= 1. If the new fill_cnt equals delay_cur, go to FADE_IN.
- **FADE_IN:** on each sample_en, write and read. wet_gain = min(255, wet_gain + GAIN_STEP). When the result is 255, go to RUN.
- **RUN:** on each sample_en, write and read. delay_req_ready = 1 only in RUN. When a request is accepted, latch delay_nxt and go to FADE_OUT. The sample in the same cycle is still processed as RUN.
- **FADE_OUT:** on each sample_en, write and read. wet_gain = max(0, wet_gain − GAIN_STEP). When the result is 0, load delay_cur ← delay_nxt and branch on the new value:
  - greater than fill_cnt: go to FILL
  - less than fill_cnt: go to DRAIN
  - equal to fill_cnt: go to FADE_IN
- wet_gain holds at 0 in FILL and DRAIN.
- Guard against FIFO flags:
  - A read requested while fifo_empty=1 is suppressed and sets err_xrun.
  - A write requested while fifo_full=1 is suppressed and sets err_xrun.
  - fill_cnt follows only the accesses actually issued.
- err_xrun clears only on reset.
- delay_req_valid is ignored outside RUN. A requester holding valid is accepted at the first RUN cycle.

## Timing
- All outputs are registered.
- sample_en at edge t produces fifo_wr_en/fifo_rd_en high during cycle t+1, for exactly one cycle.
- wet_gain, fill_cnt, delay_cur and state all update at the same edge t.
- Non-strobe cycles: enables are 0 and the state is unchanged, except the RUN → FADE_OUT transition on handshake.
- Back-to-back sample_en (every cycle) is legal. The block must then produce one pulse per strobe.
- Fade length with GAIN_STEP=8 is 32 samples in each direction:
  - in: 0, 8, …, 248, 255
  - out: 255, 247, …, 7, 0
- Reset values: fifo_wr_en=0, fifo_rd_en=0, wet_gain=0, delay_req_ready=0, busy=1, err_xrun=0, delay_cur=DEFAULT_DELAY, fill_cnt=0.
- Asserting reset mid-fade or mid-fill returns to FILL immediately. The FIFO is reset by the same reset_n.

## Test plan
- **Startup:** reset, then a sample_en every 4 cycles.
  - Required: 1000 write-only pulses, then 32 write+read pulses while wet_gain ramps 0 → 255.
  - Then RUN: busy=0, ready=1, fill_cnt=1000.
- **Increase:** in RUN, request 3000.
  - Required: 32-sample fade to 0, then 2000 write-only samples.
  - Then fade-in, ending with delay_cur=3000 and fill_cnt=3000.
- **Decrease and clamp:** in RUN, request 0.
  - Required: fade-out, DRAIN to fill_cnt=1, fade-in, delay_cur=1.
  - Separately, request 9000: required delay_cur=8191.
- **Same value / busy:** request 1000 while at 1000.
  - Required: FADE_OUT → FADE_IN with no FILL/DRAIN samples.
  - A request held during the fades stays pending with ready=0 until RUN.
- **Simultaneous:** sample_en and a handshake in the same RUN cycle.
  - Required: write+read pulse next cycle, state FADE_OUT, wet_gain still 255 after that edge.
- **Fault and reset:** force fifo_empty=1 in RUN.
  - Required: fifo_rd_en suppressed and err_xrun=1 sticky.
  - Then assert reset_n low mid-FILL: all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/reverb_delay_ctrl.sv
// Delay-line sequencer for the reverb FIFO: issues per-sample write/read enables,
// keeps occupancy equal to the programmed delay and fades the wet path across changes.
module reverb_delay_ctrl #(
  parameter int DLY_W         = 13,
  parameter int MAX_DELAY     = 8191,
  parameter int DEFAULT_DELAY = 1000,
  parameter int GAIN_STEP     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sample_en,
  input  logic [DLY_W-1:0] delay_req,
  input  logic             delay_req_valid,
  output logic             delay_req_ready,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic             fifo_rd_en,
  output logic [7:0]       wet_gain,
  output logic [DLY_W-1:0] delay_cur,
  output logic             busy,
  output logic             err_xrun
);

  typedef enum logic [2:0] {FILL, DRAIN, FADE_IN, RUN, FADE_OUT} state_t;

  localparam logic [DLY_W-1:0] MAX_D = DLY_W'(MAX_DELAY);
  localparam logic [DLY_W-1:0] DEF_D = DLY_W'(DEFAULT_DELAY);
  localparam logic [7:0]       STEP8 = 8'(GAIN_STEP);

  state_t           state_q, state_d;
  logic [DLY_W-1:0] fill_q, fill_d;
  logic [DLY_W-1:0] cur_q, cur_d;
  logic [DLY_W-1:0] nxt_q, nxt_d;
  logic [7:0]       gain_q, gain_d;
  logic             wr_q, wr_d, rd_q, rd_d;
  logic             ready_q, ready_d, busy_q, busy_d;
  logic             err_q, err_d;
  logic             want_wr, want_rd;
  logic [8:0]       gain_up;
  logic [DLY_W-1:0] req_clamped;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    gain_d  = gain_q;
    err_d   = err_q;
    want_wr = 1'b0;
    want_rd = 1'b0;
    gain_up = {1'b0, gain_q} + {1'b0, STEP8};
    req_clamped = (delay_req == '0)   ? DLY_W'(1) :
                  (delay_req > MAX_D) ? MAX_D     : delay_req;

    if (sample_en) begin
      unique case (state_q)
        FILL:    want_wr = 1'b1;
        DRAIN:   want_rd = 1'b1;
        default: begin
          want_wr = 1'b1;
          want_rd = 1'b1;
        end
      endcase
    end

    // Flag guards act per access; occupancy follows only what is actually issued.
    wr_d = want_wr && !fifo_full;
    rd_d = want_rd && !fifo_empty;
    if ((want_wr && fifo_full) || (want_rd && fifo_empty)) err_d = 1'b1;
    if (wr_d && !rd_d)      fill_d = fill_q + 1'b1;
    else if (rd_d && !wr_d) fill_d = fill_q - 1'b1;

    if (sample_en) begin
      unique case (state_q)
        FILL, DRAIN: if (fill_d == cur_q) state_d = FADE_IN;
        FADE_IN: begin
          gain_d = (gain_up > 9'd255) ? 8'hFF : gain_up[7:0];
          if (gain_d == 8'hFF) state_d = RUN;
        end
        FADE_OUT: begin
          gain_d = (gain_q > STEP8) ? gain_q - STEP8 : '0;
          if (gain_d == '0) begin
            cur_d = nxt_q;
            if (nxt_q > fill_d)      state_d = FILL;
            else if (nxt_q < fill_d) state_d = DRAIN;
            else                     state_d = FADE_IN;
          end
        end
        default: ;
      endcase
    end

    // Handshake can land on a strobe cycle; that sample was already handled as RUN above.
    if (state_q == RUN && ready_q && delay_req_valid) begin
      nxt_d   = req_clamped;
      state_d = FADE_OUT;
    end

    ready_d = (state_d == RUN);
    busy_d  = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL;
      fill_q  <= '0;
      cur_q   <= DEF_D;
      nxt_q   <= DEF_D;
      gain_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      gain_q  <= gain_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign fifo_wr_en      = wr_q;
  assign fifo_rd_en      = rd_q;
  assign wet_gain        = gain_q;
  assign delay_cur       = cur_q;
  assign delay_req_ready = ready_q;
  assign busy            = busy_q;
  assign err_xrun        = err_q;

endmodule

// File: tb/tb_reverb_delay_ctrl.sv
// Randomized bench for reverb_delay_ctrl: a FIFO occupancy model plus per-change
// expected sample sequences (fade-out, fill/drain, fade-in) built from plain arithmetic.
module tb_reverb_delay_ctrl;

  localparam int W     = 14;
  localparam int MAXD  = 8191;
  localparam int DEPTH = 8192;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         sample_en;
  logic [W-1:0] delay_req;
  logic         delay_req_valid;
  logic         delay_req_ready;
  logic         fifo_empty, fifo_full;
  logic         fifo_wr_en, fifo_rd_en;
  logic [7:0]   wet_gain;
  logic [W-1:0] delay_cur;
  logic         busy, err_xrun;

  int occ = 0;
  bit force_empty = 1'b0;
  int model_delay;
  int n_checks = 0;
  int n_pass = 0;
  int stray;
  int ready_bad;
  bit timed_out;
  int seq[$];
  int exp_q[$];

  assign fifo_empty = (occ == 0) || force_empty;
  assign fifo_full  = (occ >= DEPTH);

  always #5 clk = ~clk;

  reverb_delay_ctrl #(
    .DLY_W(W), .MAX_DELAY(MAXD), .DEFAULT_DELAY(1000), .GAIN_STEP(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sample_en(sample_en),
    .delay_req(delay_req), .delay_req_valid(delay_req_valid),
    .delay_req_ready(delay_req_ready), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
    .wet_gain(wet_gain), .delay_cur(delay_cur), .busy(busy), .err_xrun(err_xrun)
  );

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
  endtask

  function automatic int clampd(input int r);
    if (r == 0) return 1;
    if (r > MAXD) return MAXD;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    occ += int'(fifo_wr_en) - int'(fifo_rd_en);
  endtask

  task automatic idle();
    sample_en = 1'b0;
    tick();
    if (fifo_wr_en || fifo_rd_en) stray++;
  endtask

  // code = 1000*(wr + 2*rd) + wet_gain
  task automatic strobe(output int code);
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    code = 1000 * (int'(fifo_wr_en) + 2 * int'(fifo_rd_en)) + int'(wet_gain);
  endtask

  task automatic run_until_run(input int gmin, input int gmax);
    int c;
    seq.delete();
    timed_out = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      repeat ($urandom_range(gmax, gmin)) idle();
      strobe(c);
      seq.push_back(c);
      if (delay_req_ready && busy) ready_bad++;
      if (!busy) return;
    end
    timed_out = 1'b1;
  endtask

  task automatic build_exp(input int from, input int to, input bit fade_out);
    exp_q.delete();
    if (fade_out)
      for (int k = 1; k <= 32; k++) exp_q.push_back(3000 + ((255 - 8*k) > 0 ? 255 - 8*k : 0));
    for (int k = 0; k < to - from; k++) exp_q.push_back(1000);
    for (int k = 0; k < from - to; k++) exp_q.push_back(2000);
    for (int k = 1; k <= 32; k++) exp_q.push_back(3000 + ((8*k) < 255 ? 8*k : 255));
  endtask

  task automatic compare_seq(input string tag);
    int bad = 0;
    int n;
    check({tag, "_timeout"}, int'(timed_out), 0);
    check({tag, "_seq_len"}, seq.size(), exp_q.size());
    n = (seq.size() < exp_q.size()) ? seq.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (seq[i] != exp_q[i]) bad++;
    check({tag, "_seq_bad"}, bad, 0);
  endtask

  task automatic check_run(input string tag, input int d);
    check({tag, "_delay_cur"}, int'(delay_cur), d);
    check({tag, "_occupancy"}, occ, d);
    check({tag, "_ready"}, int'(delay_req_ready), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_gain"}, int'(wet_gain), 255);
    check({tag, "_stray"}, stray, 0);
    check({tag, "_ready_in_busy"}, ready_bad, 0);
  endtask

  // Issues a request from RUN; optionally on a strobe cycle and optionally leaves
  // another request held through the whole change.
  task automatic change(input string tag, input int req, input int gmax,
                        input bit simul, input bit hold, input int hold_val);
    int target = clampd(req);
    int from = occ;
    stray = 0;
    ready_bad = 0;
    delay_req = W'(req);
    delay_req_valid = 1'b1;
    sample_en = simul;
    tick();
    sample_en = 1'b0;
    if (simul) begin
      check({tag, "_hs_wr"}, int'(fifo_wr_en), 1);
      check({tag, "_hs_rd"}, int'(fifo_rd_en), 1);
      check({tag, "_hs_gain"}, int'(wet_gain), 255);
    end else begin
      check({tag, "_hs_nopulse"}, int'(fifo_wr_en || fifo_rd_en), 0);
    end
    check({tag, "_hs_ready"}, int'(delay_req_ready), 0);
    check({tag, "_hs_busy"}, int'(busy), 1);
    if (hold) delay_req = W'(hold_val);
    else delay_req_valid = 1'b0;
    run_until_run(0, gmax);
    build_exp(from, target, 1'b1);
    compare_seq(tag);
    model_delay = target;
    check_run(tag, target);
  endtask

  initial begin
    int c, r;
    reset_n = 1'b0;
    sample_en = 1'b0;
    delay_req = '0;
    delay_req_valid = 1'b0;
    #23;
    check("rst_wr", int'(fifo_wr_en), 0);
    check("rst_rd", int'(fifo_rd_en), 0);
    check("rst_gain", int'(wet_gain), 0);
    check("rst_ready", int'(delay_req_ready), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_err", int'(err_xrun), 0);
    check("rst_delay", int'(delay_cur), 1000);
    @(negedge clk);
    reset_n = 1'b1;

    stray = 0;
    ready_bad = 0;
    run_until_run(3, 3);
    build_exp(0, 1000, 1'b0);
    compare_seq("startup");
    model_delay = 1000;
    check_run("startup", 1000);

    change("inc3000", 3000, 1, 1'b0, 1'b0, 0);
    change("req0", 0, 1, 1'b0, 1'b0, 0);
    change("req9000", 9000, 1, 1'b0, 1'b0, 0);
    change("back1000", 1000, 1, 1'b0, 1'b0, 0);

    r = 700 + $urandom_range(600, 0);
    change("same1000", 1000, 1, 1'b0, 1'b1, r);
    change("held", r, 1, 1'b0, 1'b0, 0);

    for (int i = 0; i < 2; i++) begin
      r = model_delay + $urandom_range(400, 0) - 200;
      change("rand", r, 1, 1'b0, 1'b0, 0);
    end

    r = model_delay + $urandom_range(300, 0) - 150;
    change("simul", r, 1, 1'b1, 1'b0, 0);

    force_empty = 1'b1;
    strobe(c);
    check("fault_code", c, 1255);
    check("fault_err", int'(err_xrun), 1);
    force_empty = 1'b0;
    idle();
    strobe(c);
    check("fault_after_code", c, 3255);
    check("fault_sticky", int'(err_xrun), 1);
    check("fault_busy", int'(busy), 0);

    delay_req = W'(model_delay + 200);
    delay_req_valid = 1'b1;
    idle();
    delay_req_valid = 1'b0;
    for (int k = 0; k < 37; k++) strobe(c);
    check("midfill_code", c, 1000);
    check("midfill_busy", int'(busy), 1);
    #3;
    reset_n = 1'b0;
    occ = 0;
    #1;
    check("arst_wr", int'(fifo_wr_en), 0);
    check("arst_rd", int'(fifo_rd_en), 0);
    check("arst_gain", int'(wet_gain), 0);
    check("arst_ready", int'(delay_req_ready), 0);
    check("arst_busy", int'(busy), 1);
    check("arst_err", int'(err_xrun), 0);
    check("arst_delay", int'(delay_cur), 1000);
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    strobe(c);
    check("post_rst_code", c, 1000);
    check("post_rst_busy", int'(busy), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
